mesh_wormhole_arbiter: RTL
==========================

MESH_WORMHOLE_ARBITER -- requirements
Module: MESH_WormholeArbiter

Interface
REQ-001 SHALL have parameter N, default 5: number of input ports (c,n,e,s,w).
REQ-002 SHALL have parameter M, default 5: number of output ports (c,n,e,s,w).
REQ-003 SHALL have parameter CREDITS, default 4: downstream buffer depth per output, range 1..15.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port i_output_req  input  [0:M-1] x [0:N-1]  per input, requested output port.
REQ-007 SHALL have port i_tail  input  [0:N-1]  flit presented by input j is a tail flit.
REQ-008 SHALL have port i_credit  input  [0:M-1]  downstream of output i freed one slot this cycle.
REQ-009 SHALL have port o_output_grant  output  [0:N-1] x [0:M-1]  per output, one-hot granted input.
REQ-010 SHALL have port o_input_grant  output  [0:N-1]  input j's flit is transferred this cycle.
REQ-011 SHALL have port o_credit_cnt  output  [$clog2(CREDITS+1)-1:0] x [0:M-1]  credits held per output.
REQ-012 SHALL have port o_locked  output  [0:M-1]  output i is held by an in-flight packet.
REQ-013 SHALL have port o_credit_err  output  1  sticky flag, credit returned while counter full.

Function
REQ-014 Multi-hot i_output_req[j] SHALL be masked to its lowest-index set bit before arbitration.
REQ-015 Each output SHALL run an independent FSM with states IDLE and LOCKED, plus owner register and round-robin pointer (0..N-1).
REQ-016 Grants SHALL be combinational from current requests and registered state; zero-cycle latency from request to grant.
REQ-017 A grant on output i SHALL require o_credit_cnt[i] > 0; at zero credits, no grant regardless of state.
REQ-018 IDLE: grant SHALL go to the first requester at or after the pointer, searching upward with wrap from N-1 to 0.
REQ-019 IDLE, granted flit not tail: SHALL move to LOCKED with owner = granted input; pointer unchanged.
REQ-020 IDLE, granted flit is tail (single-flit packet): SHALL stay IDLE, pointer = (granted+1) mod N.
REQ-021 LOCKED: only the owner SHALL be granted, and only when it requests output i; all other requesters SHALL be denied.
REQ-022 LOCKED, owner not requesting: no grant; SHALL stay LOCKED (bubble tolerated).
REQ-023 LOCKED, owner granted with i_tail set: SHALL return to IDLE next cycle, pointer = (owner+1) mod N.
REQ-024 o_input_grant[j] SHALL be the OR over outputs of o_output_grant[i][j]; at most one bit set per input.
REQ-025 Credit counter i SHALL decrement on grant, increment on i_credit[i], and hold when both occur in the same cycle.
REQ-026 i_credit[i] with counter at CREDITS and no grant: counter SHALL hold at CREDITS and o_credit_err SHALL set.
REQ-027 A credit returned in cycle t SHALL be usable for a grant in cycle t+1, not in cycle t.
REQ-028 o_locked[i] SHALL be 1 exactly when output i's FSM is in LOCKED.

Reset
REQ-029 Under reset: every FSM SHALL go to IDLE, pointers and owners to 0, counters to CREDITS, and o_credit_err cleared.
REQ-030 Reset asserted mid-packet SHALL drop the lock unconditionally; the first post-reset cycle behaves as IDLE with full credits.
REQ-031 During the reset cycle, o_output_grant and o_input_grant SHALL be all-zero.

Verification
REQ-032 Round-robin: inputs 1,3,4 each send 1-flit packets to output 2 every cycle, CREDITS=4, credit returned each cycle -> grants 1,3,4,1,3,4...
REQ-033 Wormhole lock: input 0 sends a 3-flit packet to output 1 while input 2 requests output 1 -> grants 0,0,0 (tail), then 2; o_locked=1 for 2 cycles.
REQ-034 Credit stall: CREDITS=2, no i_credit, input 3 sends a 4-flit packet -> 2 grants, then stall with o_locked=1 and counter 0; one i_credit -> 1 more grant the following cycle.
REQ-035 Simultaneous: grant and i_credit on output 0 in the same cycle with counter=1 -> counter stays 1.
REQ-036 Overflow: i_credit[4] pulsed at counter=CREDITS -> counter stays CREDITS; o_credit_err=1 until reset.
REQ-037 Reset mid-packet: input 2 locked on output 3 after 1 of 3 flits, reset for 1 cycle -> o_locked=0, counter=CREDITS; input 0 request then granted.

Source files
------------

// File: rtl/mesh_wormhole_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mesh_wormhole_arbiter: per-output wormhole arbiter, RR + credit flow ctrl |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mesh_wormhole_arbiter #(
  parameter int N       = 5,
  parameter int M       = 5,
  parameter int CREDITS = 4
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [N-1:0][M-1:0]                     i_output_req,
  input  logic [N-1:0]                            i_tail,
  input  logic [M-1:0]                            i_credit,
  output logic [M-1:0][N-1:0]                     o_output_grant,
  output logic [N-1:0]                            o_input_grant,
  output logic [M-1:0][$clog2(CREDITS+1)-1:0]     o_credit_cnt,
  output logic [M-1:0]                            o_locked,
  output logic                                    o_credit_err
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  logic [N-1:0][M-1:0] w_req_masked;
  logic [M-1:0]        w_ovf;
  logic                err_q, err_d;

  // Each input may target only one output: keep its lowest-index request.
  always_comb begin
    w_req_masked = '0;
    for (int j = 0; j < N; j++) begin
      for (int i = M - 1; i >= 0; i--) begin
        if (i_output_req[j][i]) begin
          w_req_masked[j]    = '0;
          w_req_masked[j][i] = 1'b1;
        end
      end
    end
  end

  for (genvar i = 0; i < M; i++) begin : g_out
    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    req;
    logic [N-1:0]    gnt;
    logic [PW-1:0]   gnt_idx;
    logic            gnt_any;
    logic            ovf;

    always_comb begin
      for (int j = 0; j < N; j++) begin
        req[j] = w_req_masked[j][i];
      end
    end

    always_comb begin
      int idx;
      idx     = 0;
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      if (!reset && (cnt_q != '0)) begin
        if (state_q == ST_LOCKED) begin
          if (req[owner_q]) begin
            gnt_any = 1'b1;
            gnt_idx = owner_q;
          end
        end else begin
          // Descending scan so the last hit is the nearest one at/after ptr.
          for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) idx -= N;
            if (req[idx]) begin
              gnt_any = 1'b1;
              gnt_idx = PW'(idx);
            end
          end
        end
      end
      if (gnt_any) gnt[gnt_idx] = 1'b1;
    end

    always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      ovf     = 1'b0;
      if (gnt_any) begin
        if (i_tail[gnt_idx]) begin
          state_d = ST_IDLE;
          ptr_d   = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end else begin
          state_d = ST_LOCKED;
          owner_d = gnt_idx;
        end
      end
      if (gnt_any && !i_credit[i]) begin
        cnt_d = cnt_q - 1'b1;
      end else if (!gnt_any && i_credit[i]) begin
        if (cnt_q == CW'(CREDITS)) ovf = 1'b1;
        else                       cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= ST_IDLE;
        ptr_q   <= '0;
        owner_q <= '0;
        cnt_q   <= CW'(CREDITS);
      end else begin
        state_q <= state_d;
        ptr_q   <= ptr_d;
        owner_q <= owner_d;
        cnt_q   <= cnt_d;
      end
    end

    assign o_output_grant[i] = gnt;
    assign o_credit_cnt[i]   = cnt_q;
    assign o_locked[i]       = (state_q == ST_LOCKED);
    assign w_ovf[i]          = ovf;
  end

  always_comb begin
    o_input_grant = '0;
    for (int i = 0; i < M; i++) begin
      o_input_grant = o_input_grant | o_output_grant[i];
    end
  end

  assign err_d = err_q | (|w_ovf);

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign o_credit_err = err_q;

endmodule
`default_nettype wire
